// File: rtl/game_mode_controller.sv
// Pong gameplay sequencer (MENU/SERVE/PLAY/PAUSE/GAME_OVER), score keeper and key debouncer; optional PAUSE state via PAUSE_EN.
// Latency: key to press pulse is 2 sync + DEBOUNCE_CYCLES samples; a press or point changes the registered outputs one edge later.
// Backpressure: none; point pulses and key presses are consumed the cycle they arrive or dropped when the state ignores them.
`timescale 1ns/1ps

module game_mode_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SERVE_DELAY     = 25000000,
    parameter int SCORE_WIDTH     = 4,
    parameter int WIN_SCORE       = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   keyPlay,
    input  logic                   keyMenu,
    input  logic [1:0]             pointScored,
    output logic                   gameEnable,
    output logic                   gameReset,
    output logic [2:0]             stateCode,
    output logic [SCORE_WIDTH-1:0] scoreLeft,
    output logic [SCORE_WIDTH-1:0] scoreRight,
    output logic [1:0]             winner,
    output logic                   serveDir
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SRV_W = $clog2(SERVE_DELAY + 1);

    localparam logic [DB_W-1:0]        DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SRV_W-1:0]       SRV_LAST = SRV_W'(SERVE_DELAY - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN_VAL  = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [SCORE_WIDTH-1:0] ONE      = SCORE_WIDTH'(1);

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    // Index 0 is the play key, index 1 the menu key.
    logic [1:0]      key_raw;
    logic [1:0]      key_sync1;
    logic [1:0]      key_sync2;
    logic [1:0]      key_level;
    logic [1:0]      key_press;
    logic [DB_W-1:0] db_cnt [2];

    logic play_press;
    logic menu_press;

    state_t                 state;
    state_t                 state_nxt;
    logic [SRV_W-1:0]       serve_cnt;
    logic [SRV_W-1:0]       serve_cnt_nxt;
    logic [SCORE_WIDTH-1:0] score_l;
    logic [SCORE_WIDTH-1:0] score_l_nxt;
    logic [SCORE_WIDTH-1:0] score_r;
    logic [SCORE_WIDTH-1:0] score_r_nxt;
    logic [1:0]             winner_q;
    logic [1:0]             winner_nxt;
    logic                   serve_dir_q;
    logic                   serve_dir_nxt;
    logic                   game_enable_q;
    logic                   game_reset_q;

    assign key_raw = {keyMenu, keyPlay};

    // Level follows the synchronised key once it has disagreed for DEBOUNCE_CYCLES
    // consecutive samples; the press pulse fires only on the released-to-pressed flip.
    for (genvar k = 0; k < 2; k++) begin : g_debounce
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                key_sync1[k] <= 1'b1;
                key_sync2[k] <= 1'b1;
                key_level[k] <= 1'b1;
                key_press[k] <= 1'b0;
                db_cnt[k]    <= '0;
            end else begin
                key_sync1[k] <= key_raw[k];
                key_sync2[k] <= key_sync1[k];
                key_press[k] <= 1'b0;
                if (key_sync2[k] == key_level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    key_level[k] <= key_sync2[k];
                    key_press[k] <= key_level[k];
                    db_cnt[k]    <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign play_press = key_press[0];
    assign menu_press = key_press[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= MENU;
            serve_cnt     <= '0;
            score_l       <= '0;
            score_r       <= '0;
            winner_q      <= 2'b00;
            serve_dir_q   <= 1'b0;
            game_enable_q <= 1'b0;
            game_reset_q  <= 1'b1;
        end else begin
            state         <= state_nxt;
            serve_cnt     <= serve_cnt_nxt;
            score_l       <= score_l_nxt;
            score_r       <= score_r_nxt;
            winner_q      <= winner_nxt;
            serve_dir_q   <= serve_dir_nxt;
            game_enable_q <= (state_nxt == PLAY);
            game_reset_q  <= (state_nxt == MENU);
        end
    end

    always_comb begin
        state_nxt     = state;
        serve_cnt_nxt = '0;
        score_l_nxt   = score_l;
        score_r_nxt   = score_r;
        winner_nxt    = winner_q;
        serve_dir_nxt = serve_dir_q;

        case (state)
            MENU: begin
                if (!menu_press && play_press) begin
                    state_nxt = SERVE;
                end
            end

            SERVE: begin
                if (menu_press) begin
                    state_nxt = MENU;
                end else if (serve_cnt == SRV_LAST) begin
                    state_nxt = PLAY;
                end else begin
                    serve_cnt_nxt = serve_cnt + 1'b1;
                end
            end

            PLAY: begin
                // A point landing with a pause press is still scored; pause is dropped.
                if (menu_press) begin
                    state_nxt = MENU;
                end else if (pointScored == 2'b01) begin
                    score_l_nxt   = score_l + ONE;
                    serve_dir_nxt = 1'b1;
                    if (score_l_nxt == WIN_VAL) begin
                        state_nxt  = GAME_OVER;
                        winner_nxt = 2'b01;
                    end else begin
                        state_nxt = SERVE;
                    end
                end else if (pointScored == 2'b10) begin
                    score_r_nxt   = score_r + ONE;
                    serve_dir_nxt = 1'b0;
                    if (score_r_nxt == WIN_VAL) begin
                        state_nxt  = GAME_OVER;
                        winner_nxt = 2'b10;
                    end else begin
                        state_nxt = SERVE;
                    end
                end else if (pointScored == 2'b11) begin
                    state_nxt = SERVE;
                end
`ifdef PAUSE_EN
                else if (play_press) begin
                    state_nxt = PAUSE;
                end
`endif
            end

`ifdef PAUSE_EN
            PAUSE: begin
                if (menu_press) begin
                    state_nxt = MENU;
                end else if (play_press) begin
                    state_nxt = PLAY;
                end
            end
`endif

            GAME_OVER: begin
                if (menu_press) begin
                    state_nxt = MENU;
                end else if (play_press) begin
                    state_nxt     = SERVE;
                    score_l_nxt   = '0;
                    score_r_nxt   = '0;
                    winner_nxt    = 2'b00;
                    serve_dir_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = MENU;
            end
        endcase

        // Scores read zero on the very first cycle shown in MENU.
        if (state_nxt == MENU) begin
            score_l_nxt = '0;
            score_r_nxt = '0;
            winner_nxt  = 2'b00;
        end
    end

    assign stateCode  = state;
    assign gameEnable = game_enable_q;
    assign gameReset  = game_reset_q;
    assign scoreLeft  = score_l;
    assign scoreRight = score_r;
    assign winner     = winner_q;
    assign serveDir   = serve_dir_q;

endmodule

// File: tb/tb_game_mode_controller.sv
// Scoreboard bench for game_mode_controller: expected output snapshots are queued by the stimulus
// and a negedge monitor pops one each time the registered outputs change.
`timescale 1ns/1ps

module tb_game_mode_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       keyPlay;
    logic       keyMenu;
    logic [1:0] pointScored;
    logic       gameEnable;
    logic       gameReset;
    logic [2:0] stateCode;
    logic [3:0] scoreLeft;
    logic [3:0] scoreRight;
    logic [1:0] winner;
    logic       serveDir;

    game_mode_controller #(
        .DEBOUNCE_CYCLES(4),
        .SERVE_DELAY    (8),
        .SCORE_WIDTH    (4),
        .WIN_SCORE      (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .keyPlay    (keyPlay),
        .keyMenu    (keyMenu),
        .pointScored(pointScored),
        .gameEnable (gameEnable),
        .gameReset  (gameReset),
        .stateCode  (stateCode),
        .scoreLeft  (scoreLeft),
        .scoreRight (scoreRight),
        .winner     (winner),
        .serveDir   (serveDir)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] win;
        logic       sdir;
        logic       en;
        logic       grst;
    } snap_t;

    typedef struct {
        snap_t s;
        int    gap;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    snap_t cur_s;
    snap_t prev_s;
    exp_t  mon_e;
    int    last_cyc = 0;
    bit    mon_started = 1'b0;

    assign cur_s = {stateCode, scoreLeft, scoreRight, winner, serveDir, gameEnable, gameReset};

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_s(input logic [2:0] st, input logic [3:0] sl, input logic [3:0] sr,
                            input logic [1:0] w, input logic d, input logic en, input logic gr,
                            input int gap);
        exp_t e;
        e.s   = {st, sl, sr, w, d, en, gr};
        e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: every change of the output snapshot consumes one queued expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (!mon_started) begin
                prev_s      = cur_s;
                last_cyc    = cyc;
                mon_started = 1'b1;
            end else if (cur_s != prev_s) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_change: got %0h, required no change from %0h", cur_s, prev_s);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("snapshot", 32'(cur_s), 32'(mon_e.s));
                    if (mon_e.gap >= 0) check("dwell_cycles", 32'(cyc - last_cyc), 32'(mon_e.gap));
                end
                prev_s   = cur_s;
                last_cyc = cyc;
            end
        end
    end

    task automatic press(input bit play, input bit menu);
        @(posedge clock);
        #1;
        if (play) keyPlay = 1'b0;
        if (menu) keyMenu = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        keyPlay = 1'b1;
        keyMenu = 1'b1;
        repeat (8) @(posedge clock);
        #1;
    endtask

    task automatic point(input logic [1:0] v);
        @(posedge clock);
        #1 pointScored = v;
        @(posedge clock);
        #1 pointScored = 2'b00;
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clock);
            if (stateCode == code) hit = 1'b1;
        end
        check($sformatf("reach_state_%0d", code), 32'(stateCode), 32'(code));
    endtask

    initial begin
        reset       = 1'b1;
        keyPlay     = 1'b1;
        keyMenu     = 1'b1;
        pointScored = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state",  32'(stateCode),  32'd0);
        check("rst_gamerst", 32'(gameReset), 32'd1);
        check("rst_enable", 32'(gameEnable), 32'd0);
        check("rst_scores", 32'({scoreLeft, scoreRight}), 32'd0);
        check("rst_winner", 32'({winner, serveDir}), 32'd0);
        #1 reset = 1'b0;

        // Short glitches never reach the debounce threshold.
        repeat (3) begin
            @(posedge clock);
            #1 keyPlay = 1'b0;
            repeat (2) @(posedge clock);
            #1 keyPlay = 1'b1;
            repeat (3) @(posedge clock);
        end
        repeat (10) @(posedge clock);
        #1 check("glitch_state", 32'(stateCode), 32'd0);

        // Long hold: one press, SERVE for 8 cycles, PLAY; release adds nothing.
        expect_s(3'd1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, -1);
        expect_s(3'd2, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 8);
        @(posedge clock);
        #1 keyPlay = 1'b0;
        repeat (20) @(posedge clock);
        #1 keyPlay = 1'b1;
        repeat (12) @(posedge clock);
        #1;
        check("hold_state",  32'(stateCode),  32'd2);
        check("hold_enable", 32'(gameEnable), 32'd1);

        // Left player wins 3-0.
        expect_s(3'd1, 4'd1, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0, -1);
        expect_s(3'd2, 4'd1, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 8);
        point(2'b01);
        wait_state(3'd2, 30);
        expect_s(3'd1, 4'd2, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0, -1);
        expect_s(3'd2, 4'd2, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 8);
        point(2'b01);
        wait_state(3'd2, 30);
        expect_s(3'd4, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, 1'b0, -1);
        point(2'b01);
        wait_state(3'd4, 10);
        check("go_winner", 32'(winner), 32'd1);

        // Restart from GAME_OVER, then left point, replay, right point.
        expect_s(3'd1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, -1);
        expect_s(3'd2, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 8);
        press(1'b1, 1'b0);
        wait_state(3'd2, 30);
        expect_s(3'd1, 4'd1, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0, -1);
        expect_s(3'd2, 4'd1, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 8);
        point(2'b01);
        wait_state(3'd2, 30);
        expect_s(3'd1, 4'd1, 4'd0, 2'b00, 1'b1, 1'b0, 1'b0, -1);
        expect_s(3'd2, 4'd1, 4'd0, 2'b00, 1'b1, 1'b1, 1'b0, 8);
        point(2'b11);
        wait_state(3'd2, 30);
        expect_s(3'd1, 4'd1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, -1);
        expect_s(3'd2, 4'd1, 4'd1, 2'b00, 1'b0, 1'b1, 1'b0, 8);
        point(2'b10);
        wait_state(3'd2, 30);

`ifdef PAUSE_EN
        expect_s(3'd3, 4'd1, 4'd1, 2'b00, 1'b0, 1'b0, 1'b0, -1);
        press(1'b1, 1'b0);
        point(2'b01);
        repeat (4) @(posedge clock);
        #1 check("pause_score", 32'(scoreLeft), 32'd1);
        expect_s(3'd2, 4'd1, 4'd1, 2'b00, 1'b0, 1'b1, 1'b0, -1);
        press(1'b1, 1'b0);
        check("resume_state", 32'(stateCode), 32'd2);
`else
        press(1'b1, 1'b0);
        check("nopause_state", 32'(stateCode), 32'd2);
`endif

        // Right player reaches 3.
        expect_s(3'd1, 4'd1, 4'd2, 2'b00, 1'b0, 1'b0, 1'b0, -1);
        expect_s(3'd2, 4'd1, 4'd2, 2'b00, 1'b0, 1'b1, 1'b0, 8);
        point(2'b10);
        wait_state(3'd2, 30);
        expect_s(3'd4, 4'd1, 4'd3, 2'b10, 1'b0, 1'b0, 1'b0, -1);
        point(2'b10);
        wait_state(3'd4, 10);

        // Simultaneous menu and play: menu wins.
        expect_s(3'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, -1);
        press(1'b1, 1'b1);
        wait_state(3'd0, 10);
        check("menu_scores", 32'({scoreLeft, scoreRight}), 32'd0);

        // Asynchronous reset in SERVE.
        expect_s(3'd1, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b0, -1);
        expect_s(3'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, -1);
        @(posedge clock);
        #1 keyPlay = 1'b0;
        wait_state(3'd1, 20);
        @(posedge clock);
        #2;
        reset   = 1'b1;
        keyPlay = 1'b1;
        #1;
        check("async_rst_state",  32'(stateCode), 32'd0);
        check("async_rst_gamerst", 32'(gameReset), 32'd1);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("final_state", 32'(stateCode), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
